// File: rtl/vga_pkg.sv
// Shared SVGA 800x600@72 Hz timing constants and colour-bar palette.
// Counter widths: 11 bits horizontal (0..1039), 10 bits vertical (0..665).
package vga_pkg;

  localparam logic [10:0] HActive    = 11'd800;
  localparam logic [10:0] HFront     = 11'd56;
  localparam logic [10:0] HSync      = 11'd120;
  localparam logic [10:0] HBack      = 11'd64;
  localparam logic [10:0] HTotal     = HActive + HFront + HSync + HBack;
  localparam logic [10:0] HSyncStart = HActive + HFront;
  localparam logic [10:0] HSyncEnd   = HSyncStart + HSync - 11'd1;

  localparam logic [9:0]  VActive    = 10'd600;
  localparam logic [9:0]  VFront     = 10'd37;
  localparam logic [9:0]  VSync      = 10'd6;
  localparam logic [9:0]  VBack      = 10'd23;
  localparam logic [9:0]  VTotal     = VActive + VFront + VSync + VBack;
  localparam logic [9:0]  VSyncStart = VActive + VFront;
  localparam logic [9:0]  VSyncEnd   = VSyncStart + VSync - 10'd1;

  // RGB222 packed {R[1:0],G[1:0],B[1:0]}
  localparam logic [5:0] ColWhite   = 6'h3F;
  localparam logic [5:0] ColYellow  = 6'h3C;
  localparam logic [5:0] ColCyan    = 6'h0F;
  localparam logic [5:0] ColGreen   = 6'h0C;
  localparam logic [5:0] ColMagenta = 6'h33;
  localparam logic [5:0] ColRed     = 6'h30;
  localparam logic [5:0] ColBlue    = 6'h03;
  localparam logic [5:0] ColBlack   = 6'h00;

  // 100-pixel bars; anything past the last bar (including blanking) is black.
  function automatic logic [5:0] bar_colour(input logic [10:0] h);
    if (h < 11'd100)      return ColWhite;
    else if (h < 11'd200) return ColYellow;
    else if (h < 11'd300) return ColCyan;
    else if (h < 11'd400) return ColGreen;
    else if (h < 11'd500) return ColMagenta;
    else if (h < 11'd600) return ColRed;
    else if (h < 11'd700) return ColBlue;
    else                  return ColBlack;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with combinational de/hs/vs decode of the current counter pair.
module vga_timing
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        de,
  output logic        hs,
  output logic        vs
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HTotal - 11'd1) begin
      h_cnt <= '0;
      if (v_cnt == VTotal - 10'd1) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign de = (h_cnt < HActive) && (v_cnt < VActive);
  assign hs = (h_cnt >= HSyncStart) && (h_cnt <= HSyncEnd);
  assign vs = (v_cnt >= VSyncStart) && (v_cnt <= VSyncEnd);

endmodule

// File: rtl/main.sv
// 800x600@72 Hz colour-bar generator: timing core plus registered video outputs
// (one clock of latency behind the counters).
module main
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic       video_de,
  output logic       video_hs,
  output logic       video_vs,
  output logic [5:0] video_rgb
);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        de;
  logic        hs;
  logic        vs;
  logic [5:0]  rgb_d;

  vga_timing u_timing (
    .clk   (clk),
    .rst_n (rst_n),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .de    (de),
    .hs    (hs),
    .vs    (vs)
  );

  // bar_colour already blacks out h >= 700, so only vertical blanking needs masking here.
  always_comb begin
    rgb_d = ColBlack;
    if (v_cnt < VActive) begin
      rgb_d = bar_colour(h_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video_de  <= 1'b0;
      video_hs  <= 1'b0;
      video_vs  <= 1'b0;
      video_rgb <= 6'h00;
    end else begin
      video_de  <= de;
      video_hs  <= hs;
      video_vs  <= vs;
      video_rgb <= rgb_d;
    end
  end

endmodule

// File: tb/tb_main.sv
// Self-checking bench for the SVGA colour-bar generator: per-pixel scoreboard in
// windows, a table of hand-computed pixel vectors, and whole-frame aggregate counts.
module tb_main;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       video_de;
  logic       video_hs;
  logic       video_vs;
  logic [5:0] video_rgb;

  main dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .video_de  (video_de),
    .video_hs  (video_hs),
    .video_vs  (video_vs),
    .video_rgb (video_rgb)
  );

  always #10 clk = ~clk;

  typedef struct {
    int         f;
    int         v;
    int         h;
    logic       de;
    logic       hs;
    logic       vs;
    logic [5:0] rgb;
  } vec_t;

  localparam int LineClks  = 1040;
  localparam int FrameClks = 692640;

  vec_t        vecs[$];
  logic [8:0]  sb[$];
  logic [5:0]  bar_col [8];
  int          n_checks = 0;
  int          n_errors = 0;
  int          mh = 0;
  int          mv = 0;
  int          cyc = 0;
  bit          agg_on = 0;
  int          de_cnt = 0;
  int          hs_cnt = 0;
  int          vs_cnt = 0;
  int          vs_first = 0;
  int          hs_first = 0;
  int          rgb_bad = 0;

  function automatic logic [8:0] model(input int h, input int v);
    logic de;
    logic hs;
    logic vs;
    logic [5:0] rgb;
    de  = (h < 800) && (v < 600);
    hs  = (h >= 856) && (h <= 975);
    vs  = (v >= 637) && (v <= 642);
    rgb = de ? bar_col[h / 100] : 6'h00;
    return {de, hs, vs, rgb};
  endfunction

  function automatic logic [8:0] dut_out();
    return {video_de, video_hs, video_vs, video_rgb};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got de/hs/vs/rgb=%b/%b/%b/%02h, want %b/%b/%b/%02h", name,
               got[8], got[7], got[6], got[5:0], want[8], want[7], want[6], want[5:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic add(input int f, input int v, input int h, input logic de, input logic hs,
                     input logic vs, input logic [5:0] rgb);
    vec_t e;
    e.f = f; e.v = v; e.h = h; e.de = de; e.hs = hs; e.vs = vs; e.rgb = rgb;
    vecs.push_back(e);
  endtask

  // One clock: queue the expected decode of the model counters, let the edge
  // happen, then pop and compare inside the scoreboard windows.
  task automatic tick();
    logic [8:0] e;
    bit         chk;
    chk = (mv < 2) || (mv >= 598 && mv <= 601) || (mv >= 636 && mv <= 644) ||
          (mv >= 664) || (mv == 300);
    sb.push_back(model(mh, mv));
    @(posedge clk);
    if (mh == LineClks - 1) begin
      mh = 0;
      mv = (mv == 665) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    cyc++;
    #1;
    e = sb.pop_front();
    if (chk) check($sformatf("sb c%0d", cyc), dut_out(), e);
    if (!video_de && video_rgb != 6'h00) rgb_bad++;
    if (agg_on && cyc <= FrameClks) begin
      if (video_de) de_cnt++;
      if (video_hs) begin
        hs_cnt++;
        if (hs_first == 0) hs_first = cyc;
      end
      if (video_vs) begin
        vs_cnt++;
        if (vs_first == 0) vs_first = cyc;
      end
    end
  endtask

  initial begin
    bar_col[0] = 6'h3F; bar_col[1] = 6'h3C; bar_col[2] = 6'h0F; bar_col[3] = 6'h0C;
    bar_col[4] = 6'h33; bar_col[5] = 6'h30; bar_col[6] = 6'h03; bar_col[7] = 6'h00;

    // Pixel vectors relative to the restart after the mid-frame reset (ascending).
    add(0, 0,   0,    1, 0, 0, 6'h3F);
    add(0, 0,   99,   1, 0, 0, 6'h3F);
    add(0, 0,   100,  1, 0, 0, 6'h3C);
    add(0, 0,   250,  1, 0, 0, 6'h0F);
    add(0, 0,   399,  1, 0, 0, 6'h0C);
    add(0, 0,   450,  1, 0, 0, 6'h33);
    add(0, 0,   500,  1, 0, 0, 6'h30);
    add(0, 0,   650,  1, 0, 0, 6'h03);
    add(0, 0,   700,  1, 0, 0, 6'h00);
    add(0, 0,   799,  1, 0, 0, 6'h00);
    add(0, 0,   800,  0, 0, 0, 6'h00);
    add(0, 0,   855,  0, 0, 0, 6'h00);
    add(0, 0,   856,  0, 1, 0, 6'h00);
    add(0, 0,   975,  0, 1, 0, 6'h00);
    add(0, 0,   976,  0, 0, 0, 6'h00);
    add(0, 1,   0,    1, 0, 0, 6'h3F);
    add(0, 599, 150,  1, 0, 0, 6'h3C);
    add(0, 599, 799,  1, 0, 0, 6'h00);
    add(0, 600, 0,    0, 0, 0, 6'h00);
    add(0, 620, 900,  0, 1, 0, 6'h00);
    add(0, 636, 1039, 0, 0, 0, 6'h00);
    add(0, 637, 0,    0, 0, 1, 6'h00);
    add(0, 637, 900,  0, 1, 1, 6'h00);
    add(0, 642, 1039, 0, 0, 1, 6'h00);
    add(0, 643, 0,    0, 0, 0, 6'h00);
    add(0, 665, 1039, 0, 0, 0, 6'h00);
    add(1, 0,   0,    1, 0, 0, 6'h3F);
    add(1, 0,   1,    1, 0, 0, 6'h3F);

    rst_n = 1'b0;
    #15;
    check("reset hold", dut_out(), 9'h000);
    #6;
    rst_n = 1'b1;

    // Run into the frame and hit reset mid-line at (v=300, h=450).
    while (!(mh == 450 && mv == 300)) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset", dut_out(), 9'h000);
    @(posedge clk);
    #1;
    check("reset over edge", dut_out(), 9'h000);
    #8;
    rst_n = 1'b1;
    mh = 0;
    mv = 0;
    cyc = 0;
    agg_on = 1;

    foreach (vecs[k]) begin
      int target;
      target = vecs[k].f * FrameClks + vecs[k].v * LineClks + vecs[k].h + 1;
      while (cyc < target) tick();
      check($sformatf("vec f%0d v%0d h%0d", vecs[k].f, vecs[k].v, vecs[k].h), dut_out(),
            {vecs[k].de, vecs[k].hs, vecs[k].vs, vecs[k].rgb});
    end

    check_int("de clocks per frame", de_cnt, 800 * 600);
    check_int("hs clocks per frame", hs_cnt, 666 * 120);
    check_int("vs clocks per frame", vs_cnt, 6240);
    check_int("first vs clock", vs_first, 637 * 1040 + 1);
    check_int("first hs clock", hs_first, 857);
    check_int("rgb nonzero while de low", rgb_bad, 0);
    check_int("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 SHALL have parameters: none; all timing and colour values are fixed constants from the shared package.
REQ-002 SHALL have ports: clk  input  1  pixel clock, 50 MHz (20 ns period).
REQ-003 SHALL have ports: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports: video_de  output  1  data enable, high during active picture.
REQ-005 SHALL have ports: video_hs  output  1  horizontal sync, active-high.
REQ-006 SHALL have ports: video_vs  output  1  vertical sync, active-high.
REQ-007 SHALL have ports: video_rgb  output  6  pixel colour as RGB222, packed {R[1:0],G[1:0],B[1:0]}.

Function
REQ-008 SHALL generate 800x600@72 Hz SVGA timing directly from clk, one pixel per clock, with no clock divider.
REQ-009 SHALL keep a horizontal counter h_cnt that runs 0..1039 and wraps to 0 after 1039.
REQ-010 SHALL keep a vertical counter v_cnt that increments when h_cnt wraps, runs 0..665, and wraps to 0 when both counters are at their maximum.
REQ-011 SHALL use this horizontal layout: 0..799 active, 800..855 front porch (56), 856..975 sync (120), 976..1039 back porch (64).
REQ-012 SHALL use this vertical layout: 0..599 active, 600..636 front porch (37), 637..642 sync (6), 643..665 back porch (23).
REQ-013 SHALL register all outputs; the outputs present after a rising edge SHALL be the decode of the (h_cnt, v_cnt) pair held before that edge, giving one clock of latency.
REQ-014 SHALL drive video_de = 1 iff h_cnt < 800 and v_cnt < 600.
REQ-015 SHALL drive video_hs = 1 iff 856 <= h_cnt <= 975, on every line including vertical blanking lines.
REQ-016 SHALL drive video_vs = 1 iff 637 <= v_cnt <= 642, for whole lines; it SHALL be asserted in step with h_cnt = 0 of those lines.
REQ-017 SHALL drive video_rgb = 0 whenever video_de = 0.
REQ-018 SHALL split the active line into 8 vertical bars of 100 pixels each (bar index = h_cnt / 100).
REQ-019 SHALL use these bar colours, left to right: white 6'h3F, yellow 6'h3C, cyan 6'h0F, green 6'h0C, magenta 6'h33, red 6'h30, blue 6'h03, black 6'h00.
REQ-020 SHALL repeat the same bar pattern on every active line and every frame; there are no inputs other than clk and rst_n.
REQ-021 SHALL have a line period of exactly 1040 clocks and a frame period of exactly 692,640 clocks.

Reset
REQ-022 SHALL, while rst_n = 0, immediately force h_cnt = 0, v_cnt = 0, video_de = 0, video_hs = 0, video_vs = 0, and video_rgb = 6'h00.
REQ-023 SHALL, on the first rising edge after rst_n rises, output pixel (0,0): video_de = 1 and video_rgb = 6'h3F, and advance h_cnt to 1.
REQ-024 SHALL handle reset asserted mid-frame by forcing the outputs low at once and restarting at pixel (0,0) with no partial-frame recovery.

Structure
REQ-025 SHALL place all horizontal and vertical timing constants (active, front porch, sync, back porch, total) and the 8 bar colour constants in a shared package, vga_pkg.
REQ-026 SHALL use one sub-module, vga_timing, for the counters and the de/hs/vs decode, exporting h_cnt and v_cnt; main SHALL add the colour-bar decode and the output registers.

Verification
REQ-027 SHALL cover: hold rst_n = 0 for 21 ns -> all outputs 0; release -> video_de rises after the first edge, video_rgb = 6'h3F for 100 clocks, then 6'h3C for 100 clocks, and so on through 6'h00.
REQ-028 SHALL cover: line timing -> video_de high for 800 clocks, low for 240; video_hs rises 856 clocks after video_de rises and stays high for 120 clocks; period 1040 clocks.
REQ-029 SHALL cover: frame timing -> video_de low for all 66 lines after line 599; video_vs high for 6240 clocks starting 637 x 1040 clocks after frame start; frame period 692,640 clocks.
REQ-030 SHALL cover: at every clock where video_de = 0 -> video_rgb = 6'h00.
REQ-031 SHALL cover: assert rst_n = 0 at v_cnt = 300, h_cnt = 450 -> outputs go to 0 without waiting for a clock edge; after release, timing restarts at pixel (0,0) with full frame periods.
